// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory access controller: FSM state encodings,
// the default timeout and the byte-enable patterns that select the access
// path. The `define block is guarded so this header can be pulled into any
// compilation unit more than once.
`ifndef MEM_ACCESS_CTRL_DEFS
`define MEM_ACCESS_CTRL_DEFS
`define MAC_ST_IDLE          3'd0
`define MAC_ST_READ          3'd1
`define MAC_ST_MERGE         3'd2
`define MAC_ST_WRITE         3'd3
`define MAC_ST_RESP          3'd4
`define MAC_TIMEOUT_DEFAULT  64
`endif

package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = `MAC_ST_IDLE,
        ST_READ  = `MAC_ST_READ,
        ST_MERGE = `MAC_ST_MERGE,
        ST_WRITE = `MAC_ST_WRITE,
        ST_RESP  = `MAC_ST_RESP
    } mac_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = `MAC_TIMEOUT_DEFAULT;

    // A store with every byte enabled needs no read; with none enabled it
    // needs no memory access at all.
    localparam logic [3:0] BE_ALL  = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/mem_access_ctrl_merge.sv
// Combinational byte merge for read-modify-write stores: each byte of the
// result comes from the new store data when its enable is set, otherwise
// from the word read back from memory.
module byte_merge32 (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] o,
        input logic [31:0] n,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? n[8*i +: 8] : o[8*i +: 8];
        end
        return res;
    endfunction

    assign merged = merge_bytes(old_data, new_data, be);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller between a CPU port and a
// variable-latency RAM. Loads read once, full stores write once, partial
// stores do read / merge / write, and an all-zero byte-enable store
// completes without touching memory. Each memory phase is bounded by a
// timeout that completes the request with cpu_err set.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_finish
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mac_state_t       state_r;
    logic             we_r;
    logic [3:0]       be_r;
    logic [31:0]      rd_r;       // word read back during a partial store
    logic [CNT_W-1:0] to_cnt_r;
    logic [31:0]      merged_s;

    // mem_addr and mem_wdata double as the latched address and store word;
    // the merge overwrites mem_wdata in place before the write phase.
    byte_merge32 u_merge (
        .old_data (rd_r),
        .new_data (mem_wdata),
        .be       (be_r),
        .merged   (merged_s)
    );

    // Controller FSM with all CPU- and memory-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            we_r      <= 1'b0;
            be_r      <= 4'h0;
            rd_r      <= 32'h0000_0000;
            to_cnt_r  <= CNT_ZERO;
            cpu_rdata <= 32'h0000_0000;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            // Completion flags are single-cycle; only the RESP entry sets them.
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_r      <= cpu_we;
                        be_r      <= cpu_be;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        to_cnt_r  <= CNT_ZERO;
                        cpu_busy  <= 1'b1;
                        if (!cpu_we) begin
                            state_r <= ST_READ;
                            mem_en  <= 1'b1;
                            mem_we  <= 1'b0;
                        end else if (cpu_be == BE_ALL) begin
                            state_r <= ST_WRITE;
                            mem_en  <= 1'b1;
                            mem_we  <= 1'b1;
                        end else if (cpu_be == BE_NONE) begin
                            state_r <= ST_RESP;
                            cpu_ack <= 1'b1;
                        end else begin
                            state_r <= ST_READ;
                            mem_en  <= 1'b1;
                            mem_we  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (mem_finish) begin
                        mem_en <= 1'b0;
                        if (we_r) begin
                            rd_r    <= mem_rdata;
                            state_r <= ST_MERGE;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                            state_r   <= ST_RESP;
                        end
                    end else if (to_cnt_r == CNT_LAST) begin
                        mem_en  <= 1'b0;
                        cpu_ack <= 1'b1;
                        cpu_err <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        to_cnt_r <= to_cnt_r + CNT_ONE;
                    end
                end
                ST_MERGE: begin
                    mem_wdata <= merged_s;
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    to_cnt_r  <= CNT_ZERO;
                    state_r   <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (mem_finish) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        cpu_ack <= 1'b1;
                        state_r <= ST_RESP;
                    end else if (to_cnt_r == CNT_LAST) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        cpu_ack <= 1'b1;
                        cpu_err <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        to_cnt_r <= to_cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    cpu_busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    cpu_busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a latency RAM model. Each
// request pushes its expected (rdata, err) pair; a monitor pops and compares
// on every cpu_ack, flags acks nobody expected, and counts memory activity.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        cpu_busy;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_finish;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          en_cycles = 0;
    int          en_rises = 0;
    int          we_cycles = 0;
    int          rd_cycles = 0;
    logic        prev_en = 1'b0;

    int          ram_lat = 2;
    bit          ram_stall = 1'b0;
    int          ram_cnt;
    logic [31:0] ram [0:63];

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .cpu_busy   (cpu_busy),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_finish (mem_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency RAM: finishes ram_lat+1 cycles after mem_en is seen, one-cycle
    // mem_finish pulse; contents reload on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_finish <= 1'b0;
            mem_rdata  <= 32'h0;
            ram_cnt    <= 0;
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            ram[4]  <= 32'hDEAD_BEEF;   // 0x10
            ram[12] <= 32'hAABB_CCDD;   // 0x30
            ram[16] <= 32'h5566_7788;   // 0x40
        end else if (mem_finish) begin
            mem_finish <= 1'b0;
            ram_cnt    <= 0;
        end else if (mem_en && !ram_stall) begin
            if (ram_cnt >= ram_lat) begin
                mem_finish <= 1'b1;
                mem_rdata  <= ram[mem_addr[7:2]];
                if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
                ram_cnt <= 0;
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        check(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_en) en_cycles++;
                if (mem_en && !prev_en) en_rises++;
                if (mem_we) we_cycles++;
                if (mem_en && !mem_we) rd_cycles++;
            end
            prev_en = mem_en;
            if (cpu_ack) begin
                if (exp_q.size() == 0) begin
                    check1("unexpected_ack", cpu_ack, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_rdata", cpu_rdata, e.rdata);
                    check1("ack_err", cpu_err, e.err);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check1({tag, "_ack"}, cpu_ack, 1'b0);
        check1({tag, "_err"}, cpu_err, 1'b0);
        check1({tag, "_busy"}, cpu_busy, 1'b0);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check1({tag, "_mem_en"}, mem_en, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Push the expectation, issue one request, wait (bounded) for the ack
    // and then for the return to idle. lat counts cycles from the request
    // cycle up to and including the ack cycle. poke raises a stray request
    // while the access is in progress.
    task automatic do_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input bit poke, output int lat);
        bit seen;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) cpu_req = 1'b0;
            if (i == 1 && poke) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF;
                cpu_addr = 32'h10; cpu_wdata = 32'h0;
            end
            if (i == 2) cpu_req = 1'b0;
            if (cpu_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check1("ack_within_budget", seen, 1'b1);
        @(negedge clk);
        check1("idle_after_resp", cpu_busy, 1'b0);
    endtask

    int lat, r0, w0, e0, c0, d0;

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        rst = 1'b0;

        // Load with a stray request during the access.
        r0 = en_rises; w0 = we_cycles;
        do_op(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, lat);
        repeat (3) @(negedge clk);
        check("load_phases", 32'(en_rises - r0), 32'd1);
        check("load_no_write", 32'(we_cycles - w0), 32'd0);
        check("stray_req_ram", ram[4], 32'hDEAD_BEEF);

        // Full store, then read back.
        w0 = we_cycles; d0 = rd_cycles;
        do_op(1'b1, 4'hF, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, lat);
        check1("full_store_we", (we_cycles - w0) > 0, 1'b1);
        check("full_store_no_read", 32'(rd_cycles - d0), 32'd0);
        check("full_store_ram", ram[8], 32'h1234_5678);
        do_op(1'b0, 4'h0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 1'b0, lat);

        // Partial stores: read, merge, write.
        r0 = en_rises;
        do_op(1'b1, 4'b0101, 32'h30, 32'h1122_3344, 32'h1234_5678, 1'b0, 1'b0, lat);
        check("rmw_phases", 32'(en_rises - r0), 32'd2);
        check("rmw_ram_0101", ram[12], 32'hAA22_CC44);
        do_op(1'b1, 4'b1010, 32'h40, 32'h99AA_BBCC, 32'h1234_5678, 1'b0, 1'b0, lat);
        do_op(1'b0, 4'h0, 32'h40, 32'h0, 32'h9966_BB88, 1'b0, 1'b0, lat);

        // Zero byte-enable store: no memory access, shortest latency.
        r0 = en_rises;
        do_op(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h9966_BB88, 1'b0, 1'b0, lat);
        check("be0_latency", 32'(lat), 32'd2);
        check("be0_no_mem", 32'(en_rises - r0), 32'd0);
        check("be0_ram", ram[4], 32'hDEAD_BEEF);

        // Timeout on a load: eight READ cycles, error, rdata held.
        ram_stall = 1'b1;
        e0 = en_cycles;
        do_op(1'b0, 4'h0, 32'h10, 32'h0, 32'h9966_BB88, 1'b1, 1'b0, lat);
        check("timeout_read_cycles", 32'(en_cycles - e0), 32'd8);
        ram_stall = 1'b0;

        // Finish on the last allowed cycle wins; one cycle later is a timeout.
        ram_lat = 6;
        do_op(1'b0, 4'h0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 1'b0, lat);
        ram_lat = 7;
        do_op(1'b0, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b1, 1'b0, lat);
        ram_lat = 2;
        repeat (3) @(negedge clk);

        // Reset in the middle of a write phase.
        ram_stall = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF;
        cpu_addr = 32'h50; cpu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check1("pre_rst_write", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        c0 = checks;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ram_stall = 1'b0;
        repeat (3) @(negedge clk);
        check1("midrst_still_idle", cpu_busy, 1'b0);
        do_op(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, lat);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
